// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter for one fifo_controller write port shared by N producers.
// A winner holds the port for up to BURST accepted writes. o_wr is gated by i_full.
module fifo_wr_arbiter #(
  parameter int N     = 4,
  parameter int BURST = 4,
  parameter int SW    = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic [N-1:0]  i_req,
  input  logic          i_full,
  output logic [N-1:0]  o_gnt,
  output logic [SW-1:0] o_sel,
  output logic          o_wr,
  output logic          o_busy
);
  localparam int CW = $clog2(BURST+1);
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic {ST_IDLE, ST_BURST} state_e;

  state_e        state_q;
  logic [N-1:0]  gnt_q;
  logic [SW-1:0] sel_q;
  logic [SW-1:0] ptr_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;

  logic [SW-1:0] win_d;
  logic          win_vld;
  logic [SW-1:0] cand;
  logic          rel;

  // Scan downward in priority so the highest-priority hit (ptr+1) is written last.
  always_comb begin
    win_d   = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = N; k >= 1; k--) begin
      cand = SW'((int'(ptr_q) + k) % N);
      if (i_req[cand]) begin
        win_d   = cand;
        win_vld = 1'b1;
      end
    end
  end

  assign o_wr = busy_q & i_req[sel_q] & ~i_full;
  assign rel  = (o_wr && (cnt_q == CW'(BURST-1))) || !i_req[sel_q];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= SW'(N-1);
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_vld) begin
            state_q <= ST_BURST;
            gnt_q   <= ONE << win_d;
            sel_q   <= win_d;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        ST_BURST: begin
          if (rel) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= sel_q;
          end else if (o_wr) begin
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_gnt  = gnt_q;
  assign o_sel  = sel_q;
  assign o_busy = busy_q;

  a_gnt_onehot0: assert property (@(posedge i_clk) disable iff (!i_rstn) $onehot0(o_gnt));
  a_wr_not_full: assert property (@(posedge i_clk) disable iff (!i_rstn) o_wr |-> !i_full);
  a_wr_busy:     assert property (@(posedge i_clk) disable iff (!i_rstn) o_wr |-> o_busy);
  a_cnt_bound:   assert property (@(posedge i_clk) disable iff (!i_rstn) cnt_q < CW'(BURST));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed plan steps plus random traffic checked every cycle
// against a round-robin reference model; a second N=2/BURST=1 instance checks alternation.
module tb_fifo_wr_arbiter;
  localparam int N = 4, BURST = 4;

  logic         clk, rstn, full;
  logic [N-1:0] req, gnt;
  logic [1:0]   sel;
  logic         wr, busy;

  logic         rst2n, full2;
  logic [1:0]   req2, gnt2;
  logic         sel2, wr2, busy2;

  int checks = 0, failures = 0;
  int m_own = -1, m_cnt = 0, m_ptr = N-1;
  int wait_g[N];
  int obs_wr = 0, wr_seen = 0, snap = 0;
  logic [N-1:0] prev_gnt = '0;
  int gq[$];
  bit d2_on = 0;
  int d2_cyc = 0;

  fifo_wr_arbiter #(.N(N), .BURST(BURST)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_req(req), .i_full(full),
    .o_gnt(gnt), .o_sel(sel), .o_wr(wr), .o_busy(busy));

  fifo_wr_arbiter #(.N(2), .BURST(1)) dut2 (
    .i_clk(clk), .i_rstn(rst2n), .i_req(req2), .i_full(full2),
    .o_gnt(gnt2), .o_sel(sel2), .o_wr(wr2), .o_busy(busy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_cnt = 0; m_ptr = N-1;
  endtask

  // Expected outputs follow directly from who owns the port (-1 = nobody).
  task automatic check_outputs();
    logic [N-1:0] eg;
    logic [1:0]   eg2;
    bit           ew;
    eg = '0;
    if (m_own >= 0) eg[m_own] = 1'b1;
    ew = (m_own >= 0) && req[m_own] && !full;
    chk("gnt",  32'(gnt),  32'(eg));
    chk("sel",  32'(sel),  32'((m_own >= 0) ? m_own : 0));
    chk("busy", 32'(busy), 32'(m_own >= 0));
    chk("wr",   32'(wr),   32'(ew));
    if (wr) wr_seen++;
    if (gnt == '0) obs_wr = 0;
    else if (wr) obs_wr++;
    chk("burst_max", 32'(obs_wr <= BURST), 32'(1));
    if (gnt != '0 && prev_gnt == '0) begin
      gq.push_back(int'(sel));
      for (int j = 0; j < N; j++) begin
        if (gnt[j]) wait_g[j] = 0;
        else if (req[j]) begin
          wait_g[j]++;
          chk("starve", 32'(wait_g[j] < N), 32'(1));
        end
      end
    end
    for (int j = 0; j < N; j++) if (!req[j]) wait_g[j] = 0;
    prev_gnt = gnt;
    if (d2_on) begin
      eg2 = '0;
      if (d2_cyc % 2 == 1) eg2 = (d2_cyc % 4 == 1) ? 2'b01 : 2'b10;
      chk("d2_gnt", 32'(gnt2), 32'(eg2));
      chk("d2_sel", 32'(sel2), 32'(eg2 == 2'b10));
      chk("d2_wr",  32'(wr2),  32'(d2_cyc % 2 == 1));
    end
  endtask

  task automatic model_update();
    bit ew;
    ew = (m_own >= 0) && req[m_own] && !full;
    if (m_own < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (req[(m_ptr + k) % N]) begin
          m_own = (m_ptr + k) % N;
          m_cnt = 0;
          break;
        end
      end
    end else begin
      if (ew) m_cnt++;
      if ((ew && m_cnt == BURST) || !req[m_own]) begin
        m_ptr = m_own;
        m_own = -1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
    if (d2_on) d2_cyc++;
  endtask

  initial begin
    int guard;
    for (int j = 0; j < N; j++) wait_g[j] = 0;
    rstn = 1'b0; rst2n = 1'b0; req = 4'b1111; full = 1'b0; req2 = 2'b11; full2 = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt",  32'(gnt),  32'(0));
    chk("rst_sel",  32'(sel),  32'(0));
    chk("rst_wr",   32'(wr),   32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    req = 4'b0001;
    rstn = 1'b1; rst2n = 1'b1; d2_on = 1;

    // single requester: writes cycles 1-4, bubble 5, regrant 6
    snap = wr_seen;
    repeat (6) step();
    chk("t1_writes", 32'(wr_seen - snap), 32'(4));
    d2_on = 0;

    // all requesting: order 0,1,2,3,0
    gq.delete();
    req = 4'b1111;
    repeat (22) step();
    chk("t2_ngrants", 32'(gq.size() >= 5), 32'(1));
    if (gq.size() >= 5) begin
      chk("t2_g0", 32'(gq[0]), 32'(0));
      chk("t2_g1", 32'(gq[1]), 32'(1));
      chk("t2_g2", 32'(gq[2]), 32'(2));
      chk("t2_g3", 32'(gq[3]), 32'(3));
      chk("t2_g4", 32'(gq[4]), 32'(0));
    end

    // park the pointer on 1
    req = 4'b0010;
    guard = 0;
    while (!(m_own == -1 && m_ptr == 1) && guard < 30) begin
      step();
      guard++;
    end
    chk("t3_setup_timeout", 32'(guard < 30), 32'(1));

    // grant 2 with full during burst cycles 2-4
    req = 4'b1111; full = 1'b0;
    gq.delete();
    snap = wr_seen;
    step();
    step();
    full = 1'b1;
    repeat (3) step();
    full = 1'b0;
    repeat (3) step();
    chk("t3_winner", 32'((gq.size() > 0) ? gq[0] : -1), 32'(2));
    chk("t3_writes", 32'(wr_seen - snap), 32'(4));
    chk("t3_released", 32'(m_own), 32'(-1));

    // requester 1 withdraws after 2 writes; next grant goes to 0
    gq.delete();
    req = 4'b0010;
    repeat (3) step();
    req = 4'b0001;
    repeat (3) step();
    chk("t4_order", 32'((gq.size() == 2) ? gq[0] * 16 + gq[1] : -1), 32'(16 * 1 + 0));

    // async reset mid-burst on requester 3
    req = 4'b1000;
    repeat (4) step();
    chk("t5_owner3", 32'(gnt), 32'(4'b1000));
    #2 rstn = 1'b0;
    #1;
    chk("t5_async_gnt", 32'(gnt), 32'(0));
    chk("t5_async_wr",  32'(wr),  32'(0));
    model_reset();
    @(negedge clk);
    chk("t5_hold_wr", 32'(wr), 32'(0));
    @(posedge clk);
    #1 rstn = 1'b1;
    gq.delete();
    snap = wr_seen;
    repeat (6) step();
    chk("t5_regrant", 32'((gq.size() > 0) ? gq[0] : -1), 32'(3));
    chk("t5_writes", 32'(wr_seen - snap), 32'(4));

    // random traffic
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      full = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
